// File: rtl/billiard_pkg.sv
// billiard_pkg: shared types and constants for the cue-ball speed path.
package billiard_pkg;
    localparam int DEF_SPEED_W = 11;
    localparam int EDGE_LEFT   = 0;
    localparam int EDGE_RIGHT  = 1;
    localparam int EDGE_TOP    = 2;
    localparam int EDGE_BOTTOM = 3;
    typedef enum logic {IDLE, ROLLING} ball_state_t;
    typedef logic signed [DEF_SPEED_W-1:0] speed_t;
endpackage

// File: rtl/speed_axis_update.sv
// speed_axis_update: one axis of the per-frame update (reflect toward edge, friction, saturate).
module speed_axis_update #(
    parameter int SPEED_W       = 11,
    parameter int MAX_SPEED     = 511,
    parameter int FRICTION_STEP = 2
) (
    input  logic signed [SPEED_W-1:0] i_speed,
    input  logic                      i_neg_hit,
    input  logic                      i_pos_hit,
    input  logic                      i_friction_en,
    output logic signed [SPEED_W-1:0] o_speed
);
    localparam logic signed [SPEED_W:0]   STEP  = (SPEED_W+1)'(FRICTION_STEP);
    localparam logic signed [SPEED_W:0]   MAXV  = (SPEED_W+1)'(MAX_SPEED);
    localparam logic signed [SPEED_W:0]   NMAXV = -MAXV;
    localparam logic signed [SPEED_W-1:0] OMAX  = SPEED_W'(MAX_SPEED);
    localparam logic signed [SPEED_W-1:0] OMIN  = -OMAX;
    logic signed [SPEED_W:0] w_ext, w_refl, w_fric;
    logic                    w_flip;
    // one extra bit so negating the most negative speed cannot overflow
    always_comb begin
        w_ext   = {i_speed[SPEED_W-1], i_speed};
        w_flip  = (i_neg_hit && !i_pos_hit && w_ext < 0) || (i_pos_hit && !i_neg_hit && w_ext > 0);
        w_refl  = w_flip ? -w_ext : w_ext;
        w_fric  = !i_friction_en ? w_refl :
                  w_refl > STEP  ? w_refl - STEP :
                  w_refl < -STEP ? w_refl + STEP : '0;
        o_speed = w_fric > MAXV ? OMAX : w_fric < NMAXV ? OMIN : w_fric[SPEED_W-1:0];
    end
endmodule

// File: rtl/ball_speed_controller.sv
// ball_speed_controller: cue-ball X/Y speed with strike launch, border reflection,
// frame-rate friction and a saturating hit counter.
module ball_speed_controller
    import billiard_pkg::*;
#(
    parameter int SPEED_W         = DEF_SPEED_W,
    parameter int MAX_SPEED       = 511,
    parameter int FRICTION_PERIOD = 4,
    parameter int FRICTION_STEP   = 2,
    parameter int HIT_CNT_W       = 8
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      startOfFrame,
    input  logic                      collision,
    input  logic [3:0]                hit_edge_code,
    input  logic                      SingleHitPulse,
    input  logic                      strike,
    input  logic signed [SPEED_W-1:0] strike_x,
    input  logic signed [SPEED_W-1:0] strike_y,
    output logic signed [SPEED_W-1:0] Xspeed,
    output logic signed [SPEED_W-1:0] Yspeed,
    output logic                      ball_moving,
    output logic [HIT_CNT_W-1:0]      hit_count
);
    localparam int                        FC_W    = FRICTION_PERIOD > 1 ? $clog2(FRICTION_PERIOD) : 1;
    localparam logic [FC_W-1:0]           FC_LAST = FC_W'(FRICTION_PERIOD - 1);
    localparam logic signed [SPEED_W-1:0] MAXV    = SPEED_W'(MAX_SPEED);
    ball_state_t                r_state;
    logic [3:0]                 r_edge;
    logic [FC_W-1:0]            r_fcnt;
    logic signed [SPEED_W-1:0]  r_x, r_y;
    logic                       r_moving;
    logic [HIT_CNT_W-1:0]       r_hits;
    logic                       w_fric;
    logic signed [SPEED_W-1:0]  w_x_next, w_y_next, w_sx, w_sy;
    assign w_fric = r_fcnt == FC_LAST;
    assign w_sx   = strike_x > MAXV ? MAXV : strike_x < -MAXV ? -MAXV : strike_x;
    assign w_sy   = strike_y > MAXV ? MAXV : strike_y < -MAXV ? -MAXV : strike_y;
    assign Xspeed      = r_x;
    assign Yspeed      = r_y;
    assign ball_moving = r_moving;
    assign hit_count   = r_hits;
    speed_axis_update #(.SPEED_W(SPEED_W), .MAX_SPEED(MAX_SPEED), .FRICTION_STEP(FRICTION_STEP)) u_x (
        .i_speed(r_x), .i_neg_hit(r_edge[EDGE_LEFT]), .i_pos_hit(r_edge[EDGE_RIGHT]),
        .i_friction_en(w_fric), .o_speed(w_x_next)
    );
    speed_axis_update #(.SPEED_W(SPEED_W), .MAX_SPEED(MAX_SPEED), .FRICTION_STEP(FRICTION_STEP)) u_y (
        .i_speed(r_y), .i_neg_hit(r_edge[EDGE_TOP]), .i_pos_hit(r_edge[EDGE_BOTTOM]),
        .i_friction_en(w_fric), .o_speed(w_y_next)
    );
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state  <= IDLE;
            r_edge   <= '0;
            r_fcnt   <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_moving <= 1'b0;
            r_hits   <= '0;
        end else begin
            // a frame pulse consumes the latch; same-cycle collisions seed the next frame
            r_edge <= startOfFrame ? (collision ? hit_edge_code : 4'd0)
                                   : (collision ? r_edge | hit_edge_code : r_edge);
            if (r_state == IDLE) begin
                if (strike) begin
                    r_x    <= w_sx;
                    r_y    <= w_sy;
                    r_hits <= '0;
                    r_fcnt <= '0;
                    if (w_sx != '0 || w_sy != '0) begin
                        r_state  <= ROLLING;
                        r_moving <= 1'b1;
                    end
                end
            end else begin
                if (SingleHitPulse && !(&r_hits))
                    r_hits <= r_hits + HIT_CNT_W'(1);
                if (startOfFrame) begin
                    r_x    <= w_x_next;
                    r_y    <= w_y_next;
                    r_fcnt <= w_fric ? '0 : r_fcnt + FC_W'(1);
                    if (w_x_next == '0 && w_y_next == '0) begin
                        r_state  <= IDLE;
                        r_moving <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_ball_speed_controller.sv
// tb_ball_speed_controller: directed and random stimulus against a behavioural model,
// with a per-cycle scoreboard queue checked by an independent monitor.
module tb_ball_speed_controller;
    localparam int W = 11, MAXS = 511, P = 4, STEP = 2, HMAX = 255;
    logic clk = 0, resetN = 1, sof = 0, col = 0, hit = 0, strike = 0;
    logic [3:0] code = 0;
    logic signed [W-1:0] sx = 0, sy = 0, xs, ys;
    logic moving;
    logic [7:0] hits;
    always #5 clk = ~clk;

    ball_speed_controller dut (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .collision(col), .hit_edge_code(code),
        .SingleHitPulse(hit), .strike(strike), .strike_x(sx), .strike_y(sy),
        .Xspeed(xs), .Yspeed(ys), .ball_moving(moving), .hit_count(hits)
    );

    typedef struct {int x; int y; bit mv; int h;} exp_t;
    exp_t q[$];
    exp_t e;
    int ntests = 0, nfail = 0;
    int mx = 0, my = 0, mh = 0, mframes = 0;
    bit mmv = 0;
    bit [3:0] medge = 0;

    function void chk(string name, int act, int exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function int clamp(int v);
        return v > MAXS ? MAXS : v < -MAXS ? -MAXS : v;
    endfunction

    function int axis(int v, bit toward_neg, bit toward_pos, bit fr);
        int r;
        r = v;
        if ((toward_neg && !toward_pos && r < 0) || (toward_pos && !toward_neg && r > 0)) r = -r;
        if (fr) begin
            if (r > 0) r = (r > STEP) ? r - STEP : 0;
            else if (r < 0) r = (r < -STEP) ? r + STEP : 0;
        end
        return clamp(r);
    endfunction

    function void step(bit s, bit c, bit [3:0] cd, bit h, bit st, int x, int y);
        bit [3:0] seen;
        bit fr;
        seen = medge;
        medge = s ? (c ? cd : 4'd0) : (c ? (medge | cd) : medge);
        if (!mmv) begin
            if (st) begin
                mx = clamp(x); my = clamp(y); mh = 0; mframes = 0;
                mmv = (mx != 0 || my != 0);
            end
        end else begin
            if (h && mh < HMAX) mh++;
            if (s) begin
                mframes++;
                fr = (mframes % P) == 0;
                mx = axis(mx, seen[0], seen[1], fr);
                my = axis(my, seen[2], seen[3], fr);
                if (mx == 0 && my == 0) mmv = 0;
            end
        end
    endfunction

    task cyc(input bit s, input bit c, input bit [3:0] cd, input bit h, input bit st, input int x, input int y);
        @(negedge clk);
        sof = s; col = c; code = cd; hit = h; strike = st; sx = W'(x); sy = W'(y);
        step(s, c, cd, h, st, x, y);
        q.push_back('{mx, my, mmv, mh});
        @(posedge clk);
        #2;
    endtask

    task frame(input bit c, input bit [3:0] cd);
        cyc(1, c, cd, 0, 0, 0, 0);
        repeat (3) cyc(0, c, cd, 0, 0, 0, 0);
    endtask

    task do_reset();
        @(negedge clk);
        #2 resetN = 0;
        #1;
        chk("rst_x", int'(xs), 0);
        chk("rst_y", int'(ys), 0);
        chk("rst_mv", int'(moving), 0);
        chk("rst_hits", int'(hits), 0);
        q.delete();
        mx = 0; my = 0; mh = 0; mframes = 0; mmv = 0; medge = 0;
        sof = 0; col = 0; code = 0; hit = 0; strike = 0; sx = 0; sy = 0;
        @(negedge clk);
        resetN = 1;
    endtask

    always @(posedge clk) begin
        #1;
        if (resetN && q.size() > 0) begin
            e = q.pop_front();
            chk("sb_x", int'(xs), e.x);
            chk("sb_y", int'(ys), e.y);
            chk("sb_mv", int'(moving), int'(e.mv));
            chk("sb_hits", int'(hits), e.h);
        end
    end

    initial begin
        bit z;
        int x, y;
        do_reset();
        // launch and one friction step over four frames
        cyc(0, 0, 0, 0, 1, 30, -20);
        chk("strike_mv", int'(moving), 1);
        chk("strike_x", int'(xs), 30);
        repeat (4) frame(0, 0);
        chk("fric_x", int'(xs), 28);
        chk("fric_y", int'(ys), -18);
        // held left-edge overlap flips once only
        do_reset();
        cyc(0, 0, 0, 0, 1, -40, 100);
        cyc(0, 1, 4'b0001, 0, 0, 0, 0);
        frame(1, 4'b0001);
        chk("refl_x1", int'(xs), 40);
        repeat (2) frame(1, 4'b0001);
        chk("refl_x3", int'(xs), 40);
        // friction clamps at zero and stops the ball
        do_reset();
        cyc(0, 0, 0, 0, 1, 1, 0);
        repeat (3) frame(0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("stop_x", int'(xs), 0);
        chk("stop_mv", int'(moving), 0);
        // strike saturation and hit counter saturation
        do_reset();
        cyc(0, 0, 0, 0, 1, 1023, -1024);
        chk("sat_x", int'(xs), 511);
        chk("sat_y", int'(ys), -511);
        repeat (300) cyc(0, 0, 0, 1, 0, 0, 0);
        chk("hits_sat", int'(hits), 255);
        // bottom hit on the frame-pulse cycle belongs to the next frame
        do_reset();
        cyc(0, 0, 0, 0, 1, 0, 10);
        cyc(1, 1, 4'b1000, 0, 0, 0, 0);
        chk("late_y0", int'(ys), 10);
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("late_y1", int'(ys), -10);
        // reset while rolling, then behaves as from power-up
        do_reset();
        cyc(0, 0, 0, 0, 1, 30, -20);
        frame(0, 0);
        do_reset();
        cyc(0, 0, 0, 0, 1, 30, -20);
        repeat (4) frame(0, 0);
        chk("rr_x", int'(xs), 28);
        chk("rr_y", int'(ys), -18);
        chk("rr_mv", int'(moving), 1);
        // randomized traffic
        do_reset();
        repeat (4000) begin
            z = $urandom_range(0, 7) == 0;
            if ($urandom_range(0, 5) == 0) begin
                x = int'($urandom_range(0, 2047)) - 1024;
                y = int'($urandom_range(0, 2047)) - 1024;
            end else begin
                x = int'($urandom_range(0, 40)) - 20;
                y = int'($urandom_range(0, 40)) - 20;
            end
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 4'($urandom),
                $urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0, z ? 0 : x, z ? 0 : y);
        end
        repeat (3) @(posedge clk);
        #3;
        chk("sb_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
